mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Round-robin arbiter sharing one memory port among NUM_PORTS requesters (per-core I/D ports).
//  Sits between core fetch/load-store units and shared memory.
//  One outstanding transaction at a time; responses are routed back to the granted port.
// PARAMETERS
//  NUM_PORTS  2   number of requesters (>=2)
//  ADDR_W     32  address width
//  DATA_W     32  data width; strobe width = DATA_W/8
// PORTS
//  clk             in   1              clock, rising edge
//  rst_n           in   1              asynchronous active-low reset
//  req_valid       in   NUM_PORTS      per-port request valid
//  req_ready       out  NUM_PORTS      per-port request accepted (one-hot or zero)
//  req_we          in   NUM_PORTS      1 = write, 0 = read
//  req_addr        in   NUM_PORTS*ADDR_W  packed; port i at [i*ADDR_W +: ADDR_W]
//  req_wdata       in   NUM_PORTS*DATA_W  packed write data
//  req_wstrb       in   NUM_PORTS*DATA_W/8  packed byte strobes
//  resp_valid      out  NUM_PORTS      one-cycle response pulse to owning port
//  resp_rdata      out  DATA_W         read data, shared bus; valid with resp_valid
//  mem_req_valid   out  1              request to memory
//  mem_req_ready   in   1              memory accepts request
//  mem_we          out  1              latched write enable
//  mem_addr        out  ADDR_W         latched address
//  mem_wdata       out  DATA_W         latched write data
//  mem_wstrb       out  DATA_W/8       latched strobes
//  mem_resp_valid  in   1              memory response (reads and write acks)
//  mem_rdata       in   DATA_W         memory read data
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; last_grant=NUM_PORTS-1 (port 0 wins first);
//   req_ready=0, resp_valid=0, resp_rdata=0, mem_req_valid=0, mem_* fields=0.
//  States: IDLE -> ISSUE -> WAIT -> IDLE.
//  IDLE: winner = first i with req_valid[i], searching last_grant+1, +2, ... modulo NUM_PORTS.
//   req_ready is combinational: one-hot winner when state==IDLE and any valid, else 0.
//   On accept edge: latch we/addr/wdata/wstrb and grant index; next state=ISSUE.
//  ISSUE: mem_req_valid=1 with latched fields (stable until handshake).
//   mem_req_valid & mem_req_ready -> WAIT; otherwise hold.
//  WAIT: on mem_resp_valid: register resp_valid[grant]=1 and resp_rdata=mem_rdata (write: rdata=mem_rdata,
//   ignored by requester); last_grant<=grant; next state=IDLE.
//  resp_valid is a single-cycle pulse one cycle after mem_resp_valid; resp_rdata holds until next response.
//  Min latency: accept at edge T, mem_req_valid high in cycle T+1; 0-wait memory (ready=1, resp next cycle)
//   -> resp_valid in cycle T+3; next accept possible in that same cycle (IDLE).
//  Fairness: a continuously requesting port waits at most NUM_PORTS-1 grants.
//  Requesters must hold request fields stable until req_ready; deasserting valid before grant is legal.
//  mem_resp_valid in IDLE or ISSUE: ignored (no resp_valid, no state change).
//  mem_resp_valid in same cycle as mem_req handshake: ignored (response only counted in WAIT).
//  rst_n low mid-transaction: abort immediately; in-flight response not delivered.
//  No request valid in IDLE: stay IDLE, all outputs idle.
// TESTING
//  T1 reset: rst_n=0 mid-WAIT -> all outputs 0, state IDLE; first request after release from port 0 granted.
//  T2 single read: port1 read addr 0x100, mem returns 0xDEADBEEF -> resp_valid=2'b10 one cycle, resp_rdata=0xDEADBEEF.
//  T3 contention: both ports valid continuously, 0-wait memory -> grants alternate 0,1,0,1; resp every 3 cycles.
//  T4 backpressure: mem_req_ready=0 for 5 cycles -> mem_req_valid held, mem_addr/wdata stable; completes after ready.
//  T5 write: port0 we=1 addr 0x40 wdata 0x12345678 wstrb 4'b0011 -> mem_* match exactly; resp_valid[0] pulse on ack.
//  T6 spurious: mem_resp_valid pulsed in IDLE and ISSUE -> no resp_valid, transaction completes normally later.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port among NUM_PORTS requesters
//
// One transaction is in flight at a time. Each transaction moves through
// IDLE -> ISSUE -> WAIT -> IDLE, and its response is routed back to the port
// that was granted.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   req_valid/ready     per-port request handshake; req_ready is one-hot or zero
//   req_we/addr/wdata/wstrb   packed per-port request fields; port i sits at slice i
//   resp_valid          one-cycle pulse to the owning port
//   resp_rdata          shared read-data bus; holds until the next response
//   mem_req_valid/ready memory request handshake
//   mem_we/addr/wdata/wstrb   latched request fields, stable until the handshake
//   mem_resp_valid      memory response (read data or write ack)
//   mem_rdata           memory read data
module mem_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS-1:0]            req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]     req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]     req_wdata,
    input  logic [NUM_PORTS*(DATA_W/8)-1:0] req_wstrb,
    output logic [NUM_PORTS-1:0]            resp_valid,
    output logic [DATA_W-1:0]               resp_rdata,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic                            mem_we,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    output logic [DATA_W/8-1:0]             mem_wstrb,
    input  logic                            mem_resp_valid,
    input  logic [DATA_W-1:0]               mem_rdata
);

    localparam int SW = DATA_W / 8;
    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   grant;

    logic [GW-1:0]   scan_idx;
    logic [GW-1:0]   winner_idx;
    logic            winner_found;

    logic            sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [SW-1:0]     sel_wstrb;

    // Round-robin search: start one past the last completed grant and walk
    // forward with wrap, taking the first requesting port.
    always_comb begin
        winner_found = 1'b0;
        winner_idx   = '0;
        scan_idx     = last_grant;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (scan_idx == GW'(NUM_PORTS - 1)) begin
                scan_idx = '0;
            end else begin
                scan_idx = scan_idx + GW'(1);
            end
            if (!winner_found && req_valid[scan_idx]) begin
                winner_found = 1'b1;
                winner_idx   = scan_idx;
            end
        end
    end

    // Field mux for the winning port.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (winner_idx == GW'(i)) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_wstrb = req_wstrb[i*SW +: SW];
            end
        end
    end

    // Acceptance is combinational so a request can be taken in the same
    // cycle the previous response is delivered.
    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && winner_found) begin
            req_ready[winner_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            last_grant    <= GW'(NUM_PORTS - 1);
            grant         <= '0;
            resp_valid    <= '0;
            resp_rdata    <= '0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
        end else begin
            resp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (winner_found) begin
                        grant         <= winner_idx;
                        mem_we        <= sel_we;
                        mem_addr      <= sel_addr;
                        mem_wdata     <= sel_wdata;
                        mem_wstrb     <= sel_wstrb;
                        mem_req_valid <= 1'b1;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A response arriving alongside the handshake is not counted.
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        resp_valid <= NUM_PORTS'(1) << grant;
                        resp_rdata <= mem_rdata;
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
